// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the rectangle fill engine: geometry,
// port widths, FSM state encoding and small address/command helpers.
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // y*160 built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_row_base(input logic [6:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = {8'b0, y};
    return (y_ext << 7) + (y_ext << 5);
  endfunction

  function automatic logic fb_degenerate(input logic [7:0] x, input logic [6:0] y,
                                         input logic [7:0] w, input logic [6:0] h,
                                         input int fw, input int fh);
    return (w == 8'd0) || (h == 7'd0) || (int'(x) >= fw) || (int'(y) >= fh);
  endfunction

endpackage

// File: rtl/fb_addr_stepper.sv
// Column/row walker for a clipped rectangle. On load it works directly from the
// incoming command so the first pixel can be issued in the accept cycle.
module fb_addr_stepper #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [6:0]  cmd_h,
  output logic [14:0] addr,
  output logic        last
);
  import fb_pkg::*;

  localparam logic [8:0]  XLIM   = 9'(FB_W);
  localparam logic [8:0]  YLIM   = 9'(FB_H);
  localparam logic [14:0] ROW_PX = 15'(FB_W);

  logic [7:0]  xs_q, col_q;
  logic [8:0]  xe_q, ye_q;
  logic [6:0]  row_q;
  logic [14:0] base_q;

  logic [7:0]  xs_s, col_s, col_n;
  logic [8:0]  xe_s, ye_s, x_sum, y_sum;
  logic [6:0]  row_s, row_n;
  logic [14:0] base_s, base_n;
  logic        wrap;

  always_comb begin
    x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum = {2'b0, cmd_y} + {2'b0, cmd_h};
    if (load) begin
      xs_s   = cmd_x;
      col_s  = cmd_x;
      row_s  = cmd_y;
      base_s = fb_row_base(cmd_y);
      xe_s   = (x_sum > XLIM) ? XLIM : x_sum;
      ye_s   = (y_sum > YLIM) ? YLIM : y_sum;
    end else begin
      xs_s   = xs_q;
      col_s  = col_q;
      row_s  = row_q;
      base_s = base_q;
      xe_s   = xe_q;
      ye_s   = ye_q;
    end
    wrap   = (({1'b0, col_s} + 9'd1) == xe_s);
    last   = wrap && (({2'b0, row_s} + 9'd1) == ye_s);
    col_n  = wrap ? xs_s : col_s + 8'd1;
    row_n  = wrap ? row_s + 7'd1 : row_s;
    base_n = wrap ? base_s + ROW_PX : base_s;
    addr   = base_s + {7'b0, col_s};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xs_q   <= '0;
      xe_q   <= '0;
      ye_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      if (load) begin
        xs_q <= xs_s;
        xe_q <= xe_s;
        ye_q <= ye_s;
      end
      // A stalled load still captures the origin so the pending pixel is kept.
      if (load || step) begin
        col_q  <= step ? col_n  : col_s;
        row_q  <= step ? row_n  : row_s;
        base_q <= step ? base_n : base_s;
      end
    end
  end

endmodule

// File: rtl/fb_rect_filler.sv
// Solid-colour rectangle fill engine driving the VGA frame-buffer write port.
// Define FB_FILL_BLANK_ONLY_EN to restrict writes to cycles where blank=1.
module fb_rect_filler #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [6:0]  cmd_h,
  input  logic [5:0]  cmd_color,
  output logic        write_enable,
  output logic [5:0]  din,
  output logic [14:0] din_address,
  output logic        busy,
  output logic        done
);
  import fb_pkg::*;

  fill_state_e   state_q, state_n;
  logic          tail_q, tail_n;
  logic          done_n, we_n;
  logic [5:0]    din_n;
  logic [14:0]   addr_n;
  logic          accept, degen, load, step, allowed;
  logic [14:0]   stp_addr;
  logic          stp_last;

`ifdef FB_FILL_BLANK_ONLY_EN
  assign allowed = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign allowed      = 1'b1;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FILL);
  assign accept    = cmd_valid && cmd_ready;
  assign degen     = fb_degenerate(cmd_x, cmd_y, cmd_w, cmd_h, FB_W, FB_H);
  assign load      = accept && !degen;
  // tail_q marks the cycle showing the final strobe; nothing more is issued.
  assign step      = allowed && (load || ((state_q == FILL) && !tail_q));

  fb_addr_stepper #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_stepper (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .cmd_x (cmd_x),
    .cmd_y (cmd_y),
    .cmd_w (cmd_w),
    .cmd_h (cmd_h),
    .addr  (stp_addr),
    .last  (stp_last)
  );

  always_comb begin
    state_n = state_q;
    tail_n  = tail_q;
    done_n  = 1'b0;
    we_n    = step;
    din_n   = din;
    addr_n  = step ? stp_addr : din_address;
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_n = degen;
          if (!degen) begin
            state_n = FILL;
            din_n   = cmd_color;
            tail_n  = step && stp_last;
          end
        end
      end
      FILL: begin
        if (tail_q) begin
          state_n = IDLE;
          tail_n  = 1'b0;
          done_n  = 1'b1;
        end else if (step && stp_last) begin
          tail_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tail_q       <= 1'b0;
      done         <= 1'b0;
      write_enable <= 1'b0;
      din          <= '0;
      din_address  <= '0;
    end else begin
      state_q      <= state_n;
      tail_q       <= tail_n;
      done         <= done_n;
      write_enable <= we_n;
      din          <= din_n;
      din_address  <= addr_n;
    end
  end

endmodule

// File: tb/tb_fb_rect_filler.sv
// Scoreboard bench for fb_rect_filler: expected writes/done pulses are queued by
// the stimulus and popped by a negedge monitor.
module tb_fb_rect_filler;

  logic        clk = 1'b0;
  logic        rst;
  logic        blank;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [5:0]  cmd_color;
  logic        write_enable;
  logic [5:0]  din;
  logic [14:0] din_address;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fb_rect_filler #(
    .FB_W (160),
    .FB_H (120)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blank        (blank),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .write_enable (write_enable),
    .din          (din),
    .din_address  (din_address),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    bit is_done;
    int addr;
    int col;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic exp_wr(input int a, input int c);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.col     = c;
    q.push_back(e);
  endtask

  task automatic exp_done();
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = 0;
    e.col     = 0;
    q.push_back(e);
  endtask

  // Monitor: every strobe and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0 || q[0].is_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d din 0x%0h, queue head not a write",
                 din_address, din);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", 32'(din_address), 32'(mon_e.addr));
        chk("wr_din", 32'(din), 32'(mon_e.col));
      end
    end
    if (done === 1'b1) begin
      if (q.size() == 0 || !q[0].is_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 while queue head is a write or empty (size %0d)",
                 q.size());
      end else begin
        mon_e = q.pop_front();
        n_cmp++;
      end
    end
  end

  task automatic drive(input int x, input int y, input int w, input int h, input int c);
    cmd_x     = x[7:0];
    cmd_y     = y[6:0];
    cmd_w     = w[7:0];
    cmd_h     = h[6:0];
    cmd_color = c[5:0];
    cmd_valid = 1'b1;
  endtask

  // Waits for the accept edge, scrambles the command fields, then waits for done.
  task automatic finish_cmd(input int pix, input bit lat_chk);
    int n;
    n = 0;
    chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x     = 8'($urandom);
    cmd_y     = 7'($urandom);
    cmd_w     = 8'($urandom);
    cmd_h     = 7'($urandom);
    cmd_color = 6'($urandom);
    while (1) begin
      @(negedge clk);
      n++;
      if (done === 1'b1 || n >= 400) break;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end else begin
      if (lat_chk) chk("accept_to_done_cycles", 32'(n), 32'(pix + 1));
      chk("cmd_ready_in_done", 32'(cmd_ready), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"}, 32'(write_enable), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_addr"}, 32'(din_address), 32'd0);
  endtask

  initial begin
    int c0;
    int n;
    rst       = 1'b0;
    blank     = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    #1;
    chk_reset_vals("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single pixel at the origin.
    exp_wr(0, 'h3F);
    exp_done();
    drive(0, 0, 1, 1, 'h3F);
    finish_cmd(1, 1'b1);

    // Small rectangle, two rows of three.
    repeat (2) @(posedge clk);
    #1;
    exp_wr(330, 'h0C); exp_wr(331, 'h0C); exp_wr(332, 'h0C);
    exp_wr(490, 'h0C); exp_wr(491, 'h0C); exp_wr(492, 'h0C);
    exp_done();
    drive(10, 2, 3, 2, 'h0C);
    finish_cmd(6, 1'b1);

    // Clipped at the bottom-right corner, issued back-to-back in the done cycle.
    exp_wr(19198, 'h2A); exp_wr(19199, 'h2A);
    exp_done();
    drive(158, 119, 5, 5, 'h2A);
    finish_cmd(2, 1'b1);

    // Degenerate commands: zero width, x off-screen, y off-screen, zero height.
    exp_done();
    drive(5, 5, 0, 3, 'h11);
    finish_cmd(0, 1'b1);
    exp_done();
    drive(200, 5, 4, 4, 'h11);
    finish_cmd(0, 1'b1);
    exp_done();
    drive(3, 125, 2, 2, 'h11);
    finish_cmd(0, 1'b1);
    exp_done();
    drive(3, 4, 2, 0, 'h11);
    finish_cmd(0, 1'b1);

    // Blank gating: 3x2 at (20,10) while blank is low.
    @(posedge clk);
    #1;
    blank = 1'b0;
    exp_wr(1620, 'h07); exp_wr(1621, 'h07); exp_wr(1622, 'h07);
    exp_wr(1780, 'h07); exp_wr(1781, 'h07); exp_wr(1782, 'h07);
    exp_done();
    drive(20, 10, 3, 2, 'h07);
    c0 = wr_cnt;
`ifdef FB_FILL_BLANK_ONLY_EN
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("gated_writes_while_blank_low", 32'(wr_cnt - c0), 32'd0);
    chk("busy_while_gated", 32'(busy), 32'd1);
    blank = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done === 1'b1 || n >= 50) break;
    end
    chk("gated_done_seen", 32'(done), 32'd1);
    chk("gated_writes_after_blank", 32'(wr_cnt - c0), 32'd6);
`else
    n = 0;
    finish_cmd(6, 1'b1);
    chk("ungated_writes", 32'(wr_cnt - c0), 32'd6);
    blank = 1'b1;
`endif

    // Reset during the third pixel of a 4x4 fill.
    @(posedge clk);
    #1;
    exp_wr(0, 'h15); exp_wr(1, 'h15);
    drive(0, 0, 4, 4, 'h15);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_we", 32'(write_enable), 32'd1);
    chk("pre_reset_addr", 32'(din_address), 32'd2);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_fill_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_wr(485, 'h2B); exp_wr(486, 'h2B);
    exp_done();
    drive(5, 3, 2, 1, 'h2B);
    finish_cmd(2, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
